// File: rtl/rng_entropy_sched_if.sv
// Handshake bundle between the entropy scheduler, its two requesters and the
// TRNG core. The scheduler sits on the slave side; the requester/TRNG
// environment drives the master side.
interface rng_entropy_sched_if;
  logic       sw_flush;
  logic       sw_req;
  logic       prng_req;
  logic       ent_ack;
  logic       ehr_valid;
  logic       trng_err;
  logic       rnd_src_en;
  logic       ehr_clr;
  logic       sw_gnt;
  logic       prng_gnt;
  logic       ent_valid;
  logic       ent_fail;
  logic [1:0] fail_code;
  logic [3:0] retry_cnt;
  logic       sched_busy;

  modport master (
    output sw_flush, sw_req, prng_req, ent_ack, ehr_valid, trng_err,
    input  rnd_src_en, ehr_clr, sw_gnt, prng_gnt, ent_valid, ent_fail,
           fail_code, retry_cnt, sched_busy
  );

  modport slave (
    input  sw_flush, sw_req, prng_req, ent_ack, ehr_valid, trng_err,
    output rnd_src_en, ehr_clr, sw_gnt, prng_gnt, ent_valid, ent_fail,
           fail_code, retry_cnt, sched_busy
  );
endinterface

// File: rtl/rng_entropy_sched.sv
// TRNG entropy scheduler: arbitrates round-robin between the software path
// and the PRNG reseed path, runs the noise source for the granted owner,
// retries on health-test errors, enforces a per-attempt timeout and hands the
// EHR block (or a failure code) to the owner with a valid/ack handshake.
module rng_entropy_sched #(
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned TMR_W       = 16
) (
  input logic               rng_clk,
  input logic               rst,
  rng_entropy_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    RESTART,
    DELIVER,
    FAIL
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [1:0]       CODE_RETRY   = 2'b01;
  localparam logic [1:0]       CODE_TIMEOUT = 2'b10;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [3:0]       retry, retry_nxt;
  logic [1:0]       code, code_nxt;
  logic             sw_gnt_r, sw_gnt_nxt;
  logic             prng_gnt_r, prng_gnt_nxt;
  logic             last_sw, last_sw_nxt;
  logic             clr_r, clr_nxt;
  logic             src_r, src_nxt;
  logic             owner_req;
  logic             any_req;
  logic             win_prng;
  logic [3:0]       retry_inc;

  // The owner's own request line decides whether a COLLECT is aborted; PRNG
  // takes a tie only when software was the last one served.
  always_comb begin
    owner_req = (sw_gnt_r & bus.sw_req) | (prng_gnt_r & bus.prng_req);
    any_req   = bus.sw_req | bus.prng_req;
    win_prng  = bus.prng_req & (~bus.sw_req | last_sw);
    retry_inc = retry + 4'd1;
  end

  // Next-state and next-output decode; every output is registered so the
  // TRNG sees glitch-free enable and clear controls.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    retry_nxt    = retry;
    code_nxt     = code;
    sw_gnt_nxt   = sw_gnt_r;
    prng_gnt_nxt = prng_gnt_r;
    last_sw_nxt  = last_sw;
    clr_nxt      = 1'b0;
    src_nxt      = 1'b0;

    if (bus.sw_flush) begin
      state_nxt    = IDLE;
      timer_nxt    = '0;
      retry_nxt    = '0;
      code_nxt     = '0;
      sw_gnt_nxt   = 1'b0;
      prng_gnt_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state_nxt    = COLLECT;
            timer_nxt    = '0;
            retry_nxt    = '0;
            code_nxt     = '0;
            prng_gnt_nxt = win_prng;
            sw_gnt_nxt   = ~win_prng;
            last_sw_nxt  = ~win_prng;
            src_nxt      = 1'b1;
          end
        end

        COLLECT: begin
          timer_nxt = timer + 1'b1;
          if (bus.trng_err) begin
            retry_nxt = retry_inc;
            if (retry_inc < RETRY_MAX) begin
              state_nxt = RESTART;
              timer_nxt = '0;
              clr_nxt   = 1'b1;
            end else begin
              state_nxt = FAIL;
              code_nxt  = CODE_RETRY;
            end
          end else if (bus.ehr_valid) begin
            state_nxt = DELIVER;
          end else if (timer == TMR_LAST) begin
            state_nxt = FAIL;
            code_nxt  = CODE_TIMEOUT;
          end else if (!owner_req) begin
            state_nxt    = IDLE;
            clr_nxt      = 1'b1;
            sw_gnt_nxt   = 1'b0;
            prng_gnt_nxt = 1'b0;
          end else begin
            src_nxt = 1'b1;
          end
        end

        RESTART: begin
          state_nxt = COLLECT;
          timer_nxt = '0;
          src_nxt   = 1'b1;
        end

        DELIVER: begin
          if (bus.ent_ack) begin
            state_nxt    = IDLE;
            clr_nxt      = 1'b1;
            sw_gnt_nxt   = 1'b0;
            prng_gnt_nxt = 1'b0;
          end
        end

        FAIL: begin
          if (bus.ent_ack) begin
            state_nxt    = IDLE;
            clr_nxt      = 1'b1;
            code_nxt     = '0;
            sw_gnt_nxt   = 1'b0;
            prng_gnt_nxt = 1'b0;
          end
        end

        default: begin
          state_nxt    = IDLE;
          sw_gnt_nxt   = 1'b0;
          prng_gnt_nxt = 1'b0;
          code_nxt     = '0;
        end
      endcase
    end
  end

  // State and output registers; only a true reset rewinds the arbitration
  // pointer so a software flush does not disturb fairness.
  always_ff @(posedge rng_clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      retry      <= '0;
      code       <= '0;
      sw_gnt_r   <= 1'b0;
      prng_gnt_r <= 1'b0;
      last_sw    <= 1'b1;
      clr_r      <= 1'b0;
      src_r      <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      retry      <= retry_nxt;
      code       <= code_nxt;
      sw_gnt_r   <= sw_gnt_nxt;
      prng_gnt_r <= prng_gnt_nxt;
      last_sw    <= last_sw_nxt;
      clr_r      <= clr_nxt;
      src_r      <= src_nxt;
    end
  end

  assign bus.rnd_src_en = src_r;
  assign bus.ehr_clr    = clr_r;
  assign bus.sw_gnt     = sw_gnt_r;
  assign bus.prng_gnt   = prng_gnt_r;
  assign bus.ent_valid  = (state == DELIVER);
  assign bus.ent_fail   = (state == FAIL);
  assign bus.fail_code  = code;
  assign bus.retry_cnt  = retry;
  assign bus.sched_busy = (state != IDLE);

endmodule

// File: tb/tb_rng_entropy_sched.sv
// Self-checking bench for rng_entropy_sched: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a request-level
// behavioural model of the scheduler.
module tb_rng_entropy_sched;

  localparam int MAX_RETRY   = 3;
  localparam int TIMEOUT_CYC = 20;

  // Phases of the request currently being served by the model.
  localparam int P_COLLECT = 0;
  localparam int P_RESTART = 1;
  localparam int P_DELIVER = 2;
  localparam int P_FAIL    = 3;

  logic rng_clk = 1'b0;
  logic rst     = 1'b0;

  rng_entropy_sched_if bus();

  rng_entropy_sched #(
    .MAX_RETRY  (MAX_RETRY),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (16)
  ) dut (
    .rng_clk(rng_clk),
    .rst    (rst),
    .bus    (bus)
  );

  // Free-running block clock.
  always #5 rng_clk = ~rng_clk;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  // Model: owner 0 = none, 1 = SW, 2 = PRNG; last = owner served last.
  int m_owner = 0;
  int m_last  = 1;
  int m_phase = P_COLLECT;
  int m_age   = 0;
  int m_fails = 0;
  int m_code  = 0;
  bit m_clr   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               tag, cycle, observed, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented to the DUT.
  task automatic modelStep();
    int want;
    m_clr = 1'b0;
    if (rst) begin
      m_owner = 0; m_last = 1; m_age = 0; m_fails = 0; m_code = 0;
    end else if (bus.sw_flush) begin
      m_owner = 0; m_age = 0; m_fails = 0; m_code = 0;
    end else if (m_owner == 0) begin
      if (bus.sw_req || bus.prng_req) begin
        want    = (bus.prng_req && (!bus.sw_req || m_last == 1)) ? 2 : 1;
        m_owner = want;
        m_last  = want;
        m_age   = 0;
        m_fails = 0;
        m_code  = 0;
        m_phase = P_COLLECT;
      end
    end else begin
      case (m_phase)
        P_COLLECT: begin
          m_age++;
          if (bus.trng_err) begin
            m_fails++;
            if (m_fails < MAX_RETRY) begin
              m_phase = P_RESTART;
              m_clr   = 1'b1;
            end else begin
              m_phase = P_FAIL;
              m_code  = 1;
            end
          end else if (bus.ehr_valid) begin
            m_phase = P_DELIVER;
          end else if (m_age == TIMEOUT_CYC) begin
            m_phase = P_FAIL;
            m_code  = 2;
          end else if (!((m_owner == 1) ? bus.sw_req : bus.prng_req)) begin
            m_owner = 0;
            m_clr   = 1'b1;
          end
        end
        P_RESTART: begin
          m_phase = P_COLLECT;
          m_age   = 0;
        end
        default: begin
          if (bus.ent_ack) begin
            m_owner = 0;
            m_clr   = 1'b1;
            m_code  = 0;
          end
        end
      endcase
    end
  endtask

  task automatic checkAll();
    bit active;
    active = (m_owner != 0);
    checkOutput("rnd_src_en", 32'(bus.rnd_src_en), 32'(active && m_phase == P_COLLECT));
    checkOutput("ehr_clr",    32'(bus.ehr_clr),    32'(m_clr));
    checkOutput("sw_gnt",     32'(bus.sw_gnt),     32'(m_owner == 1));
    checkOutput("prng_gnt",   32'(bus.prng_gnt),   32'(m_owner == 2));
    checkOutput("ent_valid",  32'(bus.ent_valid),  32'(active && m_phase == P_DELIVER));
    checkOutput("ent_fail",   32'(bus.ent_fail),   32'(active && m_phase == P_FAIL));
    checkOutput("fail_code",  32'(bus.fail_code),  32'(m_code));
    checkOutput("retry_cnt",  32'(bus.retry_cnt),  32'(m_fails));
    checkOutput("sched_busy", 32'(bus.sched_busy), 32'(active));
    checkOutput("one_gnt",    32'(bus.sw_gnt & bus.prng_gnt),    32'(0));
    checkOutput("valid_xor_fail", 32'(bus.ent_valid & bus.ent_fail), 32'(0));
  endtask

  // Present one cycle of inputs, clock it, advance the model, then compare.
  task automatic applyStimulus(input bit sw, input bit prng, input bit ack,
                               input bit valid, input bit err, input bit flush,
                               input bit r);
    @(negedge rng_clk);
    bus.sw_req    = sw;
    bus.prng_req  = prng;
    bus.ent_ack   = ack;
    bus.ehr_valid = valid;
    bus.trng_err  = err;
    bus.sw_flush  = flush;
    rst           = r;
    @(posedge rng_clk);
    modelStep();
    #1;
    cycle++;
    checkAll();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
  endtask

  int  grant_log[$];
  int  exp_order[4] = '{2, 1, 2, 1};
  bit  prev_sw, prev_prng;
  bit  sw, prng, ack, valid, err, fl, rr;
  int  mode;

  initial begin
    bus.sw_req = 0; bus.prng_req = 0; bus.ent_ack = 0;
    bus.ehr_valid = 0; bus.trng_err = 0; bus.sw_flush = 0;
    rst = 1;

    // Reset state.
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Single software request: 10 COLLECT cycles, ack 2 cycles after valid.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Contention: both requests held through four completions.
    doReset();
    prev_sw = 0; prev_prng = 0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 5; s++) begin
        applyStimulus(1, 1, s == 4, s == 3, 0, 0, 0);
        if (bus.sw_gnt && !prev_sw) grant_log.push_back(1);
        if (bus.prng_gnt && !prev_prng) grant_log.push_back(2);
        prev_sw = bus.sw_gnt; prev_prng = bus.prng_gnt;
      end
    end
    checkOutput("grant_count", 32'(grant_log.size()), 32'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size())
        checkOutput("grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
      else
        checkOutput("grant_order", 32'(0), 32'(exp_order[k]));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Retry twice, then success.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Retry exhaustion; third error coincides with ehr_valid.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Timeout, then ack back to IDLE.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // PRNG aborts mid-COLLECT.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Flush during DELIVER.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset while in FAIL.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with changing error/valid profiles.
    sw = 0; prng = 0; mode = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 150 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 15) == 0) sw = ~sw;
      if ($urandom_range(0, 15) == 0) prng = ~prng;
      valid = (mode != 1) && ($urandom_range(0, 11) == 0);
      err   = (mode == 2) ? ($urandom_range(0, 3) == 0)
                          : ((mode == 0) && ($urandom_range(0, 13) == 0));
      ack   = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 199) == 0);
      rr    = ($urandom_range(0, 299) == 0);
      applyStimulus(sw, prng, ack, valid, err, fl, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
